// File: rtl/adder_rr_scheduler_pkg.sv
// Shared definitions for the round-robin adder scheduler: FSM state
// encoding and an index-width helper used to size requester ids.
package adder_rr_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Width needed to hold an index in 0..value-1, never less than one bit
   // so a two-requester build still has a usable id field.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      for (int w = 1; w < 32; w++) begin
         if ((1 << width) < value) begin
            width = width + 1;
         end
      end
      return width;
   endfunction

endpackage

// File: rtl/adder_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: scans requests starting at ptr and
// returns the first active one as a one-hot grant plus its index.
module rr_pick
   import adder_rr_scheduler_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = clog2(NREQ)
) (
   input  logic [NREQ-1:0] ireq,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] ogrant,
   output logic [IW-1:0]   oidx,
   output logic            oany
);

   // Walk the requesters from ptr upward with wrap; the first hit wins.
   always_comb begin
      int cand;
      ogrant = '0;
      oidx   = '0;
      oany   = 1'b0;
      cand   = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!oany && ireq[cand]) begin
            oany         = 1'b1;
            oidx         = IW'(cand);
            ogrant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one external registered adder between
// NREQ requesters. One operation at a time: grant, issue, wait for the
// adder's registered sum, then hold the result until the consumer takes it.
module adder_rr_scheduler
   import adder_rr_scheduler_pkg::*;
#(
   parameter  int WL   = 4,
   parameter  int NREQ = 4,
   localparam int IW   = clog2(NREQ)
) (
   input  logic               iCLK,
   input  logic               iRSTn,
   input  logic [NREQ-1:0]    ireq,
   input  logic [NREQ*WL-1:0] idata1,
   input  logic [NREQ*WL-1:0] idata2,
   output logic [NREQ-1:0]    ogrant,
   output logic               oadd_en,
   output logic [WL-1:0]      oadd_a,
   output logic [WL-1:0]      oadd_b,
   input  logic [WL:0]        iadd_sum,
   output logic               ovalid,
   output logic [WL:0]        osum,
   output logic [IW-1:0]      oid,
   input  logic               irdy
);

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     id_q, id_d;
   logic [WL-1:0]     add_a_q, add_a_d;
   logic [WL-1:0]     add_b_q, add_b_d;
   logic              add_en_q, add_en_d;
   logic              valid_q, valid_d;
   logic [WL:0]       sum_q, sum_d;
   logic [IW-1:0]     oid_q, oid_d;
   logic [NREQ-1:0]   grant_c;

   logic [NREQ-1:0]   pick_grant;
   logic [IW-1:0]     pick_idx;
   logic              pick_any;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .ireq   (ireq),
      .ptr    (ptr_q),
      .ogrant (pick_grant),
      .oidx   (pick_idx),
      .oany   (pick_any)
   );

   // Next-state and output decode; operands are captured at the grant edge
   // so they appear during ISSUE and then simply hold.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      add_a_d  = add_a_q;
      add_b_d  = add_b_q;
      add_en_d = 1'b0;
      valid_d  = valid_q;
      sum_d    = sum_q;
      oid_d    = oid_q;
      grant_c  = '0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_c  = pick_grant;
               add_a_d  = idata1[pick_idx*WL +: WL];
               add_b_d  = idata2[pick_idx*WL +: WL];
               id_d     = pick_idx;
               ptr_d    = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
               add_en_d = 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            sum_d   = iadd_sum;
            oid_d   = id_q;
            valid_d = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (irdy) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously so an in-flight
   // operation is dropped without emitting a result.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         add_a_q  <= '0;
         add_b_q  <= '0;
         add_en_q <= 1'b0;
         valid_q  <= 1'b0;
         sum_q    <= '0;
         oid_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         add_a_q  <= add_a_d;
         add_b_q  <= add_b_d;
         add_en_q <= add_en_d;
         valid_q  <= valid_d;
         sum_q    <= sum_d;
         oid_q    <= oid_d;
      end
   end

   // Grant is a same-cycle pulse; it is masked while reset is held so that
   // pending requests cannot leak a grant during reset.
   assign ogrant  = grant_c & {NREQ{iRSTn}};
   assign oadd_en = add_en_q;
   assign oadd_a  = add_a_q;
   assign oadd_b  = add_b_q;
   assign ovalid  = valid_q;
   assign osum    = sum_q;
   assign oid     = oid_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed self-checking bench for adder_rr_scheduler with a behavioural
// model of the shared registered adder.
module tb_adder_rr_scheduler;

   localparam int WL   = 4;
   localparam int NREQ = 4;

   logic              iCLK;
   logic              iRSTn;
   logic [NREQ-1:0]   ireq;
   logic [NREQ*WL-1:0] idata1;
   logic [NREQ*WL-1:0] idata2;
   logic [NREQ-1:0]   ogrant;
   logic              oadd_en;
   logic [WL-1:0]     oadd_a;
   logic [WL-1:0]     oadd_b;
   logic [WL:0]       iadd_sum;
   logic              ovalid;
   logic [WL:0]       osum;
   logic [1:0]        oid;
   logic              irdy;

   int errorCount = 0;
   int checkCount = 0;

   int expIds[5]  = '{0, 1, 2, 3, 0};
   int expSums[5] = '{8, 16, 11, 30, 8};

   adder_rr_scheduler #(
      .WL   (WL),
      .NREQ (NREQ)
   ) dut (
      .iCLK     (iCLK),
      .iRSTn    (iRSTn),
      .ireq     (ireq),
      .idata1   (idata1),
      .idata2   (idata2),
      .ogrant   (ogrant),
      .oadd_en  (oadd_en),
      .oadd_a   (oadd_a),
      .oadd_b   (oadd_b),
      .iadd_sum (iadd_sum),
      .ovalid   (ovalid),
      .osum     (osum),
      .oid      (oid),
      .irdy     (irdy)
   );

   // Free-running 10-unit clock.
   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   // External shared adder: registers the sum one cycle after enable.
   always @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         iadd_sum <= '0;
      end else if (oadd_en) begin
         iadd_sum <= {1'b0, oadd_a} + {1'b0, oadd_b};
      end
   end

   // Counts one comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives all request-side inputs, then lets combinational grant settle.
   task automatic applyStimulus(input logic [NREQ-1:0] req,
                                input logic [NREQ*WL-1:0] a,
                                input logic [NREQ*WL-1:0] b,
                                input logic rdy);
      ireq   = req;
      idata1 = a;
      idata2 = b;
      irdy   = rdy;
      #1;
   endtask

   // Advances one clock and moves just past the edge.
   task automatic stepClock;
      @(posedge iCLK);
      #1;
   endtask

   // Checks that every scheduler output is at its cleared value.
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_grant"}, 32'(ogrant), 32'd0);
      checkOutput({tag, "_add_en"}, 32'(oadd_en), 32'd0);
      checkOutput({tag, "_add_a"}, 32'(oadd_a), 32'd0);
      checkOutput({tag, "_add_b"}, 32'(oadd_b), 32'd0);
      checkOutput({tag, "_valid"}, 32'(ovalid), 32'd0);
      checkOutput({tag, "_sum"}, 32'(osum), 32'd0);
      checkOutput({tag, "_id"}, 32'(oid), 32'd0);
   endtask

   // Directed scenario sequence.
   initial begin
      iRSTn = 1'b0;
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
      checkAllZero("reset");
      stepClock;
      stepClock;
      iRSTn = 1'b1;
      stepClock;

      // Single request: 3 + 5 from requester 0.
      applyStimulus(4'b0001, 16'h0003, 16'h0005, 1'b1);
      checkOutput("single_grant", 32'(ogrant), 32'd1);
      checkOutput("single_en_idle", 32'(oadd_en), 32'd0);
      stepClock;
      checkOutput("single_grant_drop", 32'(ogrant), 32'd0);
      checkOutput("single_add_en", 32'(oadd_en), 32'd1);
      checkOutput("single_add_a", 32'(oadd_a), 32'd3);
      checkOutput("single_add_b", 32'(oadd_b), 32'd5);
      applyStimulus(4'b0000, 16'h0009, 16'h0009, 1'b1);
      stepClock;
      checkOutput("single_en_wait", 32'(oadd_en), 32'd0);
      checkOutput("single_valid_wait", 32'(ovalid), 32'd0);
      checkOutput("single_hold_a", 32'(oadd_a), 32'd3);
      stepClock;
      checkOutput("single_valid", 32'(ovalid), 32'd1);
      checkOutput("single_sum", 32'(osum), 32'd8);
      checkOutput("single_id", 32'(oid), 32'd0);
      stepClock;
      checkOutput("single_valid_drop", 32'(ovalid), 32'd0);

      // Reset pulse in IDLE to bring the pointer back to requester 0.
      iRSTn = 1'b0;
      #2;
      iRSTn = 1'b1;
      stepClock;

      // All requesters active: round-robin 0,1,2,3,0 every four cycles.
      applyStimulus(4'b1111, 16'hFA73, 16'hF195, 1'b1);
      for (int n = 0; n < 5; n++) begin
         checkOutput("rr_grant", 32'(ogrant), 32'(1 << expIds[n]));
         stepClock;
         checkOutput("rr_add_en", 32'(oadd_en), 32'd1);
         stepClock;
         stepClock;
         checkOutput("rr_valid", 32'(ovalid), 32'd1);
         checkOutput("rr_sum", 32'(osum), 32'(expSums[n]));
         checkOutput("rr_id", 32'(oid), 32'(expIds[n]));
         checkOutput("rr_no_grant_hold", 32'(ogrant), 32'd0);
         stepClock;
      end

      // Move the pointer to 3 by serving requester 2, with backpressure.
      applyStimulus(4'b0100, 16'hFA73, 16'hF195, 1'b0);
      checkOutput("bp_grant", 32'(ogrant), 32'b0100);
      stepClock;
      applyStimulus(4'b1001, 16'hFA73, 16'hF195, 1'b0);
      checkOutput("bp_ignore_issue", 32'(ogrant), 32'd0);
      stepClock;
      stepClock;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", 32'(ovalid), 32'd1);
         checkOutput("bp_sum", 32'(osum), 32'd11);
         checkOutput("bp_id", 32'(oid), 32'd2);
         checkOutput("bp_no_grant", 32'(ogrant), 32'd0);
         stepClock;
      end
      applyStimulus(4'b1001, 16'hFA73, 16'hF195, 1'b1);
      checkOutput("bp_rdy_no_grant", 32'(ogrant), 32'd0);
      checkOutput("bp_rdy_valid", 32'(ovalid), 32'd1);
      stepClock;

      // Wrap: pointer at 3 with requesters 0 and 3 active.
      checkOutput("wrap_valid_drop", 32'(ovalid), 32'd0);
      checkOutput("wrap_grant3", 32'(ogrant), 32'b1000);
      stepClock;
      stepClock;
      stepClock;
      checkOutput("wrap_sum", 32'(osum), 32'd30);
      checkOutput("wrap_id", 32'(oid), 32'd3);
      stepClock;
      checkOutput("wrap_grant0", 32'(ogrant), 32'b0001);

      // Reset while the requester-0 operation is in WAIT.
      stepClock;
      stepClock;
      applyStimulus(4'b0000, 16'hFA73, 16'hF195, 1'b1);
      iRSTn = 1'b0;
      #1;
      checkAllZero("rst_wait");
      stepClock;
      iRSTn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         stepClock;
         checkOutput("rst_no_valid", 32'(ovalid), 32'd0);
      end
      applyStimulus(4'b1111, 16'hFA73, 16'hF195, 1'b1);
      checkOutput("rst_first_grant", 32'(ogrant), 32'b0001);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
